// File: rtl/mem_pkg.sv
// Shared definitions for the memory-subsystem register file: default sizing,
// address-width helper and the bit-masked merge used by storage and bypass.
package mem_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W = 64;

  // Address bits needed to index n words (at least one bit).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Masked bits come from new_w, the rest keep old_w.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] mask
  );
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/en_register.sv
// One storage word: per-bit masked load when en_i is high, sync active-low reset to RESET_VAL.
// Latency 1 (new value on q_o after the edge); no backpressure, always accepts.
module en_register
  import mem_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = WIDTH'(merge(MERGE_W'(q_q), MERGE_W'(d_i), MERGE_W'(mask_i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/en_reg_file.sv
// DEPTH x WIDTH register file, one masked write port, two registered read ports (latency 1).
// No backpressure: every cycle accepts a write and both reads; bad write address flags wr_err.
module en_reg_file
  import mem_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter int               AW        = clog2(DEPTH),
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             wr_err
);

  localparam logic [31:0] DEPTH_U = DEPTH;

  logic [WIDTH-1:0] words [DEPTH];
  logic [DEPTH-1:0] word_en;

  logic             waddr_ok;
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             wr_err_q, wr_err_d;

  assign waddr_ok = 32'(waddr) < DEPTH_U;
  assign wr_ok    = we && waddr_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_en[i] = we && (waddr == AW'(i));

    en_register #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (word_en[i]),
      .mask_i (wmask),
      .d_i    (wdata),
      .q_o    (words[i])
    );
  end

  // Read muxes; addresses past DEPTH match no word and read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) rd_a = words[i];
      if (raddr_b == AW'(i)) rd_b = words[i];
    end
  end

  // Same-edge write to the word being read: forward the merged word when bypassing.
  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (re_a) begin
      rdata_a_d = rd_a;
      if (BYPASS && wr_ok && (raddr_a == waddr)) begin
        rdata_a_d = WIDTH'(merge(MERGE_W'(rd_a), MERGE_W'(wdata), MERGE_W'(wmask)));
      end
    end
    if (re_b) begin
      rdata_b_d = rd_b;
      if (BYPASS && wr_ok && (raddr_b == waddr)) begin
        rdata_b_d = WIDTH'(merge(MERGE_W'(rd_b), MERGE_W'(wdata), MERGE_W'(wmask)));
      end
    end
    wr_err_d = we && !waddr_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign wr_err  = wr_err_q;

endmodule
